// File: rtl/barrel_pkg.sv
// Shared defaults and FSM state type for the barrel sequencer slice.
package barrel_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned SELW_DEF  = 3;
    localparam int unsigned STEPW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/barrel_seq_ctrl_if.sv
// Request/response bus of the barrel sequencer.
// master = requester/consumer side, slave = controller side.
interface barrel_seq_ctrl_if
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SELW  = SELW_DEF,
    parameter int unsigned STEPW = STEPW_DEF
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [SELW-1:0]  req_sel;
    logic [STEPW-1:0] req_steps;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_last;

    modport master (
        output req_valid, req_data, req_sel, req_steps, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_data, req_sel, req_steps, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last
    );

endinterface

// File: rtl/barrel_seq_ctrl_barrel.sv
// Combinational barrel shifter: rotates the word left by (sel mod WIDTH).
module barrel
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SELW  = SELW_DEF
) (
    input  logic [WIDTH-1:0] in,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] out
);

    logic [31:0] amt;

    // Rotate-left; amt==0 makes the right-hand term shift out completely.
    always_comb begin
        amt = 32'(sel) % 32'(WIDTH);
        out = (in << amt) | (in >> (32'(WIDTH) - amt));
    end

endmodule

// File: rtl/barrel_seq_ctrl.sv
// Barrel sequencer: accepts a word, applies the barrel shifter a programmed
// number of times and emits the intermediate word after every pass.
module barrel_seq_ctrl
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SELW  = SELW_DEF,
    parameter int unsigned STEPW = STEPW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    barrel_seq_ctrl_if.slave   bus,
    output logic               busy
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shf;
    logic [SELW-1:0]  sel_q;
    logic [STEPW-1:0] cnt;
    logic             accept;
    logic             rsp_hs;

    barrel #(
        .WIDTH (WIDTH),
        .SELW  (SELW)
    ) u_barrel (
        .in  (acc),
        .sel (sel_q),
        .out (shf)
    );

    // Handshake outputs; rst masks them so a same-cycle handshake is aborted.
    always_comb begin
        bus.req_ready = (state == IDLE) && !rst;
        bus.rsp_valid = (state == OUT) && !rst;
        bus.rsp_data  = acc;
        bus.rsp_last  = (state == OUT) && (cnt == '0) && !rst;
        busy          = (state != IDLE);
        accept        = bus.req_valid && bus.req_ready;
        rsp_hs        = bus.rsp_valid && bus.rsp_ready;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (bus.req_steps == '0) ? OUT : SHIFT;
                end
            end
            SHIFT: begin
                state_nx = OUT;
            end
            OUT: begin
                if (rsp_hs) begin
                    state_nx = (cnt == '0) ? IDLE : SHIFT;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath registers: capture on accept, one shifter pass per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            sel_q <= '0;
        end else if (accept) begin
            acc   <= bus.req_data;
            cnt   <= bus.req_steps;
            sel_q <= bus.req_sel;
        end else if (state == SHIFT) begin
            acc   <= shf;
            cnt   <= cnt - STEPW'(1);
        end
    end

endmodule

// File: tb/tb_barrel_seq_ctrl.sv
// Scoreboard bench for barrel_seq_ctrl with a rotate-left reference model.
module tb_barrel_seq_ctrl;
    import barrel_pkg::*;

    localparam int unsigned W = WIDTH_DEF;
    localparam int unsigned S = SELW_DEF;
    localparam int unsigned N = STEPW_DEF;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   mode  = 0;
    exp_t sbq[$];

    barrel_seq_ctrl_if #(.WIDTH(W), .SELW(S), .STEPW(N)) bus ();

    barrel_seq_ctrl #(.WIDTH(W), .SELW(S), .STEPW(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer back-pressure: 0 = always ready, 1 = random, 2 = stalled.
    always @(posedge clk) begin
        #1;
        case (mode)
            0:       bus.rsp_ready = 1'b1;
            1:       bus.rsp_ready = 1'($urandom_range(0, 1));
            default: bus.rsp_ready = 1'b0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rot(input logic [W-1:0] x, input int unsigned s);
        logic [W-1:0] r;
        int unsigned  a;
        a = s % W;
        for (int unsigned i = 0; i < W; i++) r[(i + a) % W] = x[i];
        return r;
    endfunction

    // Monitor: every response handshake is compared with the queue head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got data %0h last %0b, expected no response",
                         bus.rsp_data, bus.rsp_last);
            end else begin
                e = sbq.pop_front();
                chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                chk("rsp_last", 32'(bus.rsp_last), 32'(e.last));
                if (e.due >= 0) chk("rsp_cycle", 32'(cyc + 1), 32'(e.due));
            end
        end
    end

    // Present a request, wait for acceptance, push the expected responses.
    task automatic issue(input logic [W-1:0] d, input logic [S-1:0] s,
                         input logic [N-1:0] n, input bit timed);
        int           t;
        int           nn;
        bit           ok;
        logic [W-1:0] cur;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        bus.req_sel   = s;
        bus.req_steps = n;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got req_ready=0 for 1000 cycles, expected 1");
            bus.req_valid = 1'b0;
            return;
        end
        t   = cyc + 1;
        nn  = int'(n);
        cur = d;
        if (nn == 0) begin
            sbq.push_back('{d, 1'b1, timed ? t + 1 : -1});
        end else begin
            for (int k = 1; k <= nn; k++) begin
                cur = rot(cur, int'(s));
                sbq.push_back('{cur, (k == nn), timed ? t + 2 * k : -1});
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && busy === 1'b0) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drain_%s: got %0d responses outstanding, expected 0", nm, sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp_valid(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (bus.rsp_valid === 1'b1) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got rsp_valid=0 for 50 cycles, expected 1", nm);
        end
    endtask

    initial begin
        logic [W-1:0] hd;
        logic         hl;

        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.req_sel   = '0;
        bus.req_steps = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("rst_rsp_last",  32'(bus.rsp_last),  32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Zero steps: single pass-through response one cycle after accept.
        issue(4'hA, 3'h0, 4'h0, 1'b1);
        drain("steps0");

        // Three passes with rsp_ready held high.
        issue(4'hA, 3'h1, 4'h3, 1'b1);
        drain("steps3");

        // Every select value, one pass.
        for (int s = 0; s < 8; s++) begin
            issue(4'hA, 3'(s), 4'h1, 1'b1);
            drain("sweep");
        end

        // Maximum step count: 15 responses, last only on the final one.
        issue(4'h1, 3'h1, 4'hF, 1'b1);
        drain("max_steps");

        // Back-pressure: response held stable, new requests refused.
        mode = 2;
        issue(4'h5, 3'h1, 4'h2, 1'b0);
        wait_rsp_valid("hold_wait");
        hd = bus.rsp_data;
        hl = bus.rsp_last;
        bus.req_valid = 1'b1;
        bus.req_data  = 4'hC;
        bus.req_steps = 4'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_data",  32'(bus.rsp_data),  32'(hd));
            chk("hold_last",  32'(bus.rsp_last),  32'(hl));
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        mode = 0;
        drain("hold");

        // Random requests under random back-pressure.
        mode = 1;
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), S'($urandom), N'($urandom), 1'b0);
        end
        drain("random");
        mode = 0;
        @(posedge clk);
        #1;

        // Reset while a response is offered and the consumer is ready.
        issue(4'h3, 3'h1, 4'h3, 1'b0);
        wait_rsp_valid("abort_wait");
        rst = 1'b1;
        #1;
        chk("abort_no_hs", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_busy",      32'(busy),          32'd0);
        chk("abort_rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("abort_rsp_last",  32'(bus.rsp_last),  32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
        sbq.delete();
        rst = 1'b0;
        #1;
        chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
        issue(4'h9, 3'h2, 4'h2, 1'b1);
        drain("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
